// File: rtl/det_sec_sched.sv
// det_sec_sched: round-robin scheduler that time-shares one serial sequence
// detector between two parallel-word requesters. Each frame clears the
// detector, shifts the granted word in MSB-first, appends DRAIN zero bits so
// late matches still register, and reports the detector hit count with an ack.
module det_sec_sched #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4,
  parameter int DRAIN  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [WORD_W-1:0] data0,
  input  logic              req1,
  input  logic [WORD_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic              det_rst,
  output logic              det_s_in,
  input  logic              det_valido,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              hit
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // One cycle counter serves both the SHIFT bit index and the DRAIN index.
  localparam int CYC_W = $clog2(WORD_W + DRAIN + 1);
  localparam logic [CYC_W-1:0] LAST_BIT   = CYC_W'(WORD_W - 1);
  localparam logic [CYC_W-1:0] LAST_DRAIN = CYC_W'(DRAIN - 1);
  localparam logic [CYC_W-1:0] CYC_ONE    = CYC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [2:0]        r_state;
  logic [WORD_W-1:0] r_shift;
  logic [CYC_W-1:0]  r_cyc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_id;
  logic              r_last;
  logic              r_sin;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic              r_done_id;

  logic [2:0]        w_next;
  logic              w_grant_id;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_counting;

  // Pick the winner: a lone requester wins outright, a tie goes to the one not served last.
  always_comb begin
    w_grant_id = 1'b0;
    if (req0 && req1) begin
      w_grant_id = ~r_last;
    end else if (req1) begin
      w_grant_id = 1'b1;
    end
  end

  // Saturating hit counter increment, active only while the word or drain bits are in flight.
  always_comb begin
    w_counting = (r_state == S_SHIFT) || (r_state == S_DRAIN);
    w_cnt_next = r_cnt;
    if (w_counting && det_valido && (r_cnt != CNT_MAX)) begin
      w_cnt_next = r_cnt + CNT_ONE;
    end
  end

  // Frame sequencing: IDLE -> CLR -> SHIFT x WORD_W -> DRAIN x DRAIN -> DONE -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req0 || req1) w_next = S_CLR;
      S_CLR:   w_next = S_SHIFT;
      S_SHIFT: if (r_cyc == LAST_BIT) w_next = (DRAIN == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (r_cyc == LAST_DRAIN) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and report registers; the report is loaded on entry to DONE so it lines up with the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cyc     <= '0;
      r_cnt     <= '0;
      r_id      <= 1'b0;
      r_last    <= 1'b1;
      r_sin     <= 1'b0;
      r_hit_cnt <= '0;
      r_done_id <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          r_sin <= 1'b0;
          if (req0 || req1) begin
            r_shift <= w_grant_id ? data1 : data0;
            r_id    <= w_grant_id;
          end
        end
        S_CLR: begin
          r_cnt   <= '0;
          r_cyc   <= '0;
          r_sin   <= r_shift[WORD_W-1];
          r_shift <= r_shift << 1;
        end
        S_SHIFT: begin
          r_cnt <= w_cnt_next;
          if (r_cyc == LAST_BIT) begin
            r_cyc <= '0;
            r_sin <= 1'b0;
          end else begin
            r_cyc   <= r_cyc + CYC_ONE;
            r_sin   <= r_shift[WORD_W-1];
            r_shift <= r_shift << 1;
          end
        end
        S_DRAIN: begin
          r_cnt <= w_cnt_next;
          r_cyc <= r_cyc + CYC_ONE;
          r_sin <= 1'b0;
        end
        S_DONE: begin
          r_last <= r_id;
          r_sin  <= 1'b0;
        end
        default: begin
          r_sin <= 1'b0;
        end
      endcase
      if (w_counting && (w_next == S_DONE)) begin
        r_hit_cnt <= w_cnt_next;
        r_done_id <= r_id;
      end
    end
  end

  // Outputs decoded from state; det_rst also follows rst so the detector resets with us.
  always_comb begin
    det_rst  = rst || (r_state == S_CLR);
    det_s_in = r_sin;
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
    ack0     = (r_state == S_DONE) && !r_id;
    ack1     = (r_state == S_DONE) && r_id;
    done_id  = r_done_id;
    hit_cnt  = r_hit_cnt;
    hit      = (r_hit_cnt != '0);
  end

endmodule

// File: tb/tb_det_sec_sched.sv
// tb_det_sec_sched: directed bench for det_sec_sched. A default instance and a
// narrow-counter (CNT_W=3) instance share all inputs; the bench plays the
// detector by driving det_valido with per-frame patterns.
module tb_det_sec_sched;

  logic       clock;
  logic       reset;
  logic       req0;
  logic [7:0] data0;
  logic       req1;
  logic [7:0] data1;
  logic       detValido;

  logic       ack0, ack1, detRst, detSIn, busy, done, doneId, hit;
  logic [3:0] hitCnt;
  logic       s3Ack0, s3Ack1, s3DetRst, s3DetSIn, s3Busy, s3Done, s3DoneId, s3Hit;
  logic [2:0] s3HitCnt;

  int totalChecks = 0;
  int badChecks   = 0;

  // Per-frame capture filled in by runFrame.
  logic [9:0] sinVec;
  int         doneAt;
  int         rstCycles;
  logic       earlyAck;
  logic       gotAck0, gotAck1, gotId, gotHit, gotHit3, gotDone3;
  logic [3:0] gotCnt;
  logic [2:0] gotCnt3;

  det_sec_sched #(.WORD_W(8), .CNT_W(4), .DRAIN(2)) dut (
    .clk(clock), .rst(reset),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1),
    .det_rst(detRst), .det_s_in(detSIn), .det_valido(detValido),
    .busy(busy), .done(done), .done_id(doneId),
    .hit_cnt(hitCnt), .hit(hit)
  );

  det_sec_sched #(.WORD_W(8), .CNT_W(3), .DRAIN(2)) dut3 (
    .clk(clock), .rst(reset),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(s3Ack0), .ack1(s3Ack1),
    .det_rst(s3DetRst), .det_s_in(s3DetSIn), .det_valido(detValido),
    .busy(s3Busy), .done(s3Done), .done_id(s3DoneId),
    .hit_cnt(s3HitCnt), .hit(s3Hit)
  );

  // 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case something upstream hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive requester inputs (called right after a falling edge).
  task automatic applyStimulus(input logic r0, input logic [7:0] d0, input logic r1, input logic [7:0] d1);
    req0  = r0;
    data0 = d0;
    req1  = r1;
    data1 = d1;
  endtask

  // Follow one frame. u is the cycle index where u=1 is CLR; lead=1 when the
  // first sampled cycle is the IDLE grant cycle. valPat[u] drives det_valido in cycle u.
  task automatic runFrame(input logic [15:0] valPat, input int lead, input bit dropOnAck);
    int u;
    sinVec    = '0;
    doneAt    = -1;
    rstCycles = 0;
    earlyAck  = 1'b0;
    for (int t = 1; t <= 40 && doneAt < 0; t++) begin
      @(negedge clock);
      u = t - lead;
      if (detRst && u >= 1) rstCycles++;
      if (u >= 2 && u <= 11) sinVec[11-u] = detSIn;
      if (done) begin
        doneAt   = t;
        gotAck0  = ack0;
        gotAck1  = ack1;
        gotId    = doneId;
        gotCnt   = hitCnt;
        gotHit   = hit;
        gotCnt3  = s3HitCnt;
        gotHit3  = s3Hit;
        gotDone3 = s3Done;
        if (dropOnAck) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end else if (ack0 || ack1) begin
        earlyAck = 1'b1;
      end
      detValido = (u >= 0 && u <= 15) ? valPat[u] : 1'b0;
    end
    detValido = 1'b0;
  endtask

  // Compare everything captured for one frame against hand-derived values.
  task automatic checkFrame(input string name, input int expLat, input logic expId,
                            input logic [9:0] expSin, input int expCnt, input int expCnt3);
    checkOutput({name, "_latency"}, doneAt, expLat);
    checkOutput({name, "_sin"}, {22'd0, sinVec}, {22'd0, expSin});
    checkOutput({name, "_detrst_cycles"}, rstCycles, 1);
    checkOutput({name, "_early_ack"}, {31'd0, earlyAck}, 0);
    checkOutput({name, "_ack0"}, {31'd0, gotAck0}, {31'd0, ~expId});
    checkOutput({name, "_ack1"}, {31'd0, gotAck1}, {31'd0, expId});
    checkOutput({name, "_done_id"}, {31'd0, gotId}, {31'd0, expId});
    checkOutput({name, "_hit_cnt"}, {28'd0, gotCnt}, expCnt);
    checkOutput({name, "_hit"}, {31'd0, gotHit}, (expCnt != 0) ? 1 : 0);
    checkOutput({name, "_hit_cnt3"}, {29'd0, gotCnt3}, expCnt3);
    checkOutput({name, "_hit3"}, {31'd0, gotHit3}, (expCnt3 != 0) ? 1 : 0);
    checkOutput({name, "_done3"}, {31'd0, gotDone3}, 1);
  endtask

  // Directed sequence.
  initial begin
    logic sawBusy;
    logic abortAck;
    reset     = 1'b1;
    detValido = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);

    // Reset state.
    repeat (3) @(negedge clock);
    checkOutput("rst_detrst", {31'd0, detRst}, 1);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_acks", {30'd0, ack1, ack0}, 0);
    checkOutput("rst_done", {31'd0, done}, 0);
    checkOutput("rst_sin", {31'd0, detSIn}, 0);
    checkOutput("rst_report", {26'd0, doneId, hit, hitCnt}, 0);
    reset = 1'b0;

    // Idle with no requests.
    sawBusy = 1'b0;
    @(negedge clock);
    checkOutput("idle_detrst", {31'd0, detRst}, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (busy) sawBusy = 1'b1;
    end
    checkOutput("idle_busy", {31'd0, sawBusy}, 0);

    // Single requester-0 frame, no detector hits.
    applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00);
    runFrame(16'h0000, 0, 1'b1);
    checkFrame("a5", 12, 1'b0, {8'hA5, 2'b00}, 0, 0);
    @(negedge clock);
    checkOutput("after_a5_busy", {31'd0, busy}, 0);
    checkOutput("after_a5_done", {31'd0, done}, 0);

    // Requester-1 frame with hits on SHIFT bits 3, 7 and DRAIN cycle 2.
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h3C);
    runFrame(16'h0A20, 0, 1'b1);
    checkFrame("hits", 12, 1'b1, {8'h3C, 2'b00}, 3, 3);
    @(negedge clock);
    checkOutput("report_hold", {28'd0, hitCnt}, 3);

    // A det_valido pulse during CLR must not count.
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h81);
    runFrame(16'h0002, 0, 1'b1);
    checkFrame("clr", 12, 1'b1, {8'h81, 2'b00}, 0, 0);
    @(negedge clock);

    // Contention: both held, last served was 1, so grants go 0,1,0,1.
    applyStimulus(1'b1, 8'hFF, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      runFrame(16'h0000, (i == 0) ? 0 : 1, i == 3);
      checkFrame("rr", (i == 0) ? 12 : 13, logic'(i % 2),
                 (i % 2 == 1) ? 10'b0000000000 : 10'b1111111100, 0, 0);
    end
    @(negedge clock);

    // Saturation: det_valido held through all 10 SHIFT+DRAIN cycles.
    applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00);
    runFrame(16'h0FFC, 0, 1'b1);
    checkFrame("sat", 12, 1'b0, {8'h5A, 2'b00}, 10, 7);
    @(negedge clock);

    // Reset abort on SHIFT bit 4, then the still-held request runs cleanly.
    applyStimulus(1'b1, 8'hC3, 1'b0, 8'h00);
    abortAck = 1'b0;
    for (int u = 1; u <= 6; u++) begin
      @(negedge clock);
      if (ack0 || ack1 || done) abortAck = 1'b1;
    end
    reset = 1'b1;
    #1;
    checkOutput("abort_detrst", {31'd0, detRst}, 1);
    @(negedge clock);
    checkOutput("abort_ack_seen", {31'd0, abortAck}, 0);
    checkOutput("abort_busy", {31'd0, busy}, 0);
    checkOutput("abort_done_ack", {29'd0, done, ack1, ack0}, 0);
    checkOutput("abort_hit_cnt", {28'd0, hitCnt}, 0);
    checkOutput("abort_hit", {31'd0, hit}, 0);
    checkOutput("abort_hit_cnt3", {29'd0, s3HitCnt}, 0);
    reset = 1'b0;
    runFrame(16'h0000, 0, 1'b1);
    checkFrame("rereq", 12, 1'b0, {8'hC3, 2'b00}, 0, 0);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
